pwm_ramp_sequencer: RTL and testbench

Controller in front of the switch-driven PWM datapath. It owns the free-running period counter and the duty threshold. It arbitrates duty requests between the board switches and a host handshake port, and ramps the applied duty one step at a time. Duty changes take effect only at period boundaries, so `pwm_out` never produces a truncated or glitched pulse.

---
 rtl/pwm_ramp_sequencer.sv | 113 +++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer.sv
// PWM controller: free-running period counter, switch/host duty arbitration and a
// one-step-at-a-time duty ramp whose updates land only on period boundaries.
module pwm_ramp_sequencer #(
    parameter int CBITS        = 21,
    parameter int STEP_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       host_req,
    input  logic [3:0] host_duty,
    output logic       host_ack,
    output logic       pwm_out,
    output logic       period_start,
    output logic [3:0] duty_cur,
    output logic       ramping
);
    localparam int SCW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [SCW-1:0] STEP_LAST = SCW'(STEP_PERIODS - 1);
    localparam logic [CBITS-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, WAIT, STEP} state_t;

    state_t           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [3:0]       sw_q, sw_d;
    logic [3:0]       target_q, target_d;
    logic [3:0]       duty_q, duty_d;
    logic [SCW-1:0]   step_cnt_q, step_cnt_d;
    logic             host_ack_q, host_ack_d;
    logic             pwm_q, pwm_d;
    logic             period_start_q, period_start_d;
    logic             ramping_q, ramping_d;
    logic [CBITS-1:0] threshold;
    logic             boundary;

    always_comb begin
        cnt_d          = cnt_q + 1'b1;
        sw_d           = sw;
        boundary       = (cnt_q == CNT_LAST);
        // Threshold sits half a duty step above duty*2^(CBITS-5): never 0, never full.
        threshold      = {{(CBITS-5){1'b0}}, duty_q, 1'b1} << (CBITS - 6);
        pwm_d          = (cnt_q < threshold);
        period_start_d = (cnt_q == '0);

        // A request that is already acked this cycle is not re-accepted; the host wins ties.
        host_ack_d = host_req && !host_ack_q;
        target_d   = target_q;
        if (host_ack_d) begin
            target_d = host_duty;
        end else if (sw != sw_q) begin
            target_d = sw;
        end

        state_d    = state_q;
        duty_d     = duty_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            IDLE: begin
                if (target_q != duty_q) state_d = WAIT;
            end
            WAIT, STEP: begin
                // The step itself is taken on the boundary edge, not as a separate cycle.
                if (boundary) begin
                    if (target_q == duty_q) begin
                        state_d    = IDLE;
                        step_cnt_d = '0;
                    end else if (step_cnt_q == STEP_LAST) begin
                        duty_d     = (target_q > duty_q) ? duty_q + 4'd1 : duty_q - 4'd1;
                        step_cnt_d = '0;
                        state_d    = (duty_d == target_q) ? IDLE : WAIT;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ramping_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sw_q           <= '0;
            target_q       <= '0;
            duty_q         <= '0;
            step_cnt_q     <= '0;
            host_ack_q     <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            ramping_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sw_q           <= sw_d;
            target_q       <= target_d;
            duty_q         <= duty_d;
            step_cnt_q     <= step_cnt_d;
            host_ack_q     <= host_ack_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            ramping_q      <= ramping_d;
        end
    end

    assign host_ack     = host_ack_q;
    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign duty_cur     = duty_q;
    assign ramping      = ramping_q;
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer (CBITS=8, STEP_PERIODS=2): directed scenarios plus a
// random phase, each cycle compared with a period/duty reference model.
module tb_pwm_ramp_sequencer;
    localparam int CB  = 8;
    localparam int SP  = 2;
    localparam int PER = 1 << CB;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       host_req;
    logic [3:0] host_duty;
    logic       host_ack;
    logic       pwm_out;
    logic       period_start;
    logic [3:0] duty_cur;
    logic       ramping;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int m_pos, m_sw_prev, m_tgt, m_duty, m_periods, m_active;
    int m_pwm, m_ps, m_ack;

    // measurements taken from the outputs
    int hi_cnt = 0;
    int meas_on = 0;
    int cyc = 0;
    int last_ps = -1;
    int hi_q[$];
    int iv_q[$];
    int chg_q[$];

    pwm_ramp_sequencer #(.CBITS(CB), .STEP_PERIODS(SP)) dut (
        .clk(clk), .rst(rst), .sw(sw), .host_req(host_req), .host_duty(host_duty),
        .host_ack(host_ack), .pwm_out(pwm_out), .period_start(period_start),
        .duty_cur(duty_cur), .ramping(ramping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Next-state of the model for one rising edge, from the inputs currently driven.
    task automatic model_edge();
        int high_time, n_tgt, n_duty, n_periods, n_active;
        if (rst) begin
            m_pos = 0; m_sw_prev = 0; m_tgt = 0; m_duty = 0; m_periods = 0;
            m_active = 0; m_pwm = 0; m_ps = 0; m_ack = 0;
            return;
        end
        high_time = m_duty * (1 << (CB - 5)) + (1 << (CB - 6));
        m_pwm = (m_pos < high_time) ? 1 : 0;
        m_ps  = (m_pos == 0) ? 1 : 0;
        n_tgt = m_tgt;
        if (host_req && m_ack == 0) begin
            n_tgt = host_duty;
            m_ack = 1;
        end else begin
            m_ack = 0;
            if (int'(sw) != m_sw_prev) n_tgt = sw;
        end
        m_sw_prev = sw;
        n_duty = m_duty; n_periods = m_periods; n_active = m_active;
        if (m_active == 0) begin
            n_active = (m_tgt != m_duty) ? 1 : 0;
        end else if (m_pos == PER - 1) begin
            if (m_tgt == m_duty) begin
                n_active = 0; n_periods = 0;
            end else if (m_periods + 1 >= SP) begin
                n_duty = m_duty + ((m_tgt > m_duty) ? 1 : -1);
                n_periods = 0;
                n_active = (n_duty != m_tgt) ? 1 : 0;
            end else begin
                n_periods = m_periods + 1;
            end
        end
        m_tgt = n_tgt; m_duty = n_duty; m_periods = n_periods; m_active = n_active;
        m_pos = (m_pos + 1) % PER;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        chk("pwm_out", 8'(pwm_out), 8'(m_pwm));
        chk("period_start", 8'(period_start), 8'(m_ps));
        chk("host_ack", 8'(host_ack), 8'(m_ack));
        chk("duty_cur", 8'(duty_cur), 8'(m_duty));
        chk("ramping", 8'(ramping), 8'(m_active));
        if (period_start) begin
            if (meas_on) hi_q.push_back(hi_cnt);
            if (last_ps >= 0) iv_q.push_back(cyc - last_ps);
            last_ps = cyc;
            hi_cnt  = 0;
            meas_on = 1;
        end
        if (pwm_out) hi_cnt++;
    endtask

    initial begin
        int n, acks, prev;
        logic [7:0] ack_pat[6];
        int exp_hi[7] = '{4, 4, 12, 12, 20, 20, 28};
        int exp_down[3] = '{3, 2, 1};

        rst = 1'b1; sw = 4'd0; host_req = 1'b0; host_duty = 4'd0;

        // Reset, then idle at duty 0
        for (int i = 0; i < 3; i++) cycle();
        chk("reset_duty", 8'(duty_cur), 8'd0);
        chk("reset_pwm", 8'(pwm_out), 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 3 * PER + 2; i++) cycle();
        chk("idle_periods_seen", 8'(hi_q.size()), 8'd3);
        foreach (hi_q[i]) chk("idle_high_time", 8'(hi_q[i]), 8'd4);
        foreach (iv_q[i]) chk("period_interval", 8'(iv_q[i] - PER), 8'd0);

        // Ramp 0 -> 3 requested mid-period
        n = 0;
        while (!period_start && n < 2 * PER) begin cycle(); n++; end
        chk("sync_period_start", 8'(period_start), 8'd1);
        hi_q.delete();
        for (int i = 0; i < PER / 2; i++) cycle();
        sw = 4'd3;
        n = 0;
        while (hi_q.size() < 7 && n < 9 * PER) begin cycle(); n++; end
        chk("ramp_periods_seen", 8'(hi_q.size()), 8'd7);
        for (int i = 0; i < 7 && i < hi_q.size(); i++) chk("ramp_high_time", 8'(hi_q[i]), 8'(exp_hi[i]));
        chk("ramp3_duty", 8'(duty_cur), 8'd3);
        chk("ramp3_ramping", 8'(ramping), 8'd0);

        // Host write collides with a switch change; the host wins
        sw = 4'd2; host_req = 1'b1; host_duty = 4'd9;
        cycle();
        acks = int'(host_ack);
        host_req = 1'b0;
        for (int i = 0; i < 4; i++) begin cycle(); acks += int'(host_ack); end
        chk("collide_ack_count", 8'(acks), 8'd1);
        n = 0;
        while (duty_cur == 4'd3 && n < 4 * PER) begin cycle(); n++; end
        chk("collide_first_step_up", 8'(duty_cur), 8'd4);
        n = 0;
        while (ramping && n < 16 * PER) begin cycle(); n++; end
        chk("collide_final_duty", 8'(duty_cur), 8'd9);

        // Host request held: acks alternate
        host_req = 1'b1; host_duty = 4'd9;
        ack_pat[0] = 8'(host_ack);
        for (int i = 1; i < 6; i++) begin cycle(); ack_pat[i] = 8'(host_ack); end
        cycle();
        host_req = 1'b0;
        for (int i = 0; i < 6; i++) chk("held_ack_pattern", ack_pat[i], 8'(i % 2));
        for (int i = 0; i < 4; i++) cycle();

        // Mid-ramp reversal: 0 -> 8, turned back to 1 at duty 4
        rst = 1'b1; cycle(); rst = 1'b0;
        sw = 4'd8;
        n = 0;
        while (duty_cur != 4'd4 && n < 12 * PER) begin cycle(); n++; end
        chk("reverse_reach4", 8'(duty_cur), 8'd4);
        sw = 4'd1;
        chg_q.delete();
        prev = duty_cur;
        n = 0;
        while (!(duty_cur == 4'd1 && !ramping) && n < 10 * PER) begin
            cycle(); n++;
            if (int'(duty_cur) != prev) begin
                chk("reverse_single_step", 8'(prev - int'(duty_cur)), 8'd1);
                chg_q.push_back(duty_cur);
                prev = duty_cur;
            end
        end
        chk("reverse_step_count", 8'(chg_q.size()), 8'd3);
        for (int i = 0; i < 3 && i < chg_q.size(); i++) chk("reverse_sequence", 8'(chg_q[i]), 8'(exp_down[i]));

        // Reset mid-ramp at duty 5 with a host request pending
        sw = 4'd9;
        n = 0;
        while (duty_cur != 4'd5 && n < 12 * PER) begin cycle(); n++; end
        chk("midreset_reach5", 8'(duty_cur), 8'd5);
        rst = 1'b1; host_req = 1'b1; host_duty = 4'd9;
        cycle();
        chk("midreset_duty", 8'(duty_cur), 8'd0);
        chk("midreset_pwm", 8'(pwm_out), 8'd0);
        chk("midreset_ramping", 8'(ramping), 8'd0);
        rst = 1'b0;
        cycle();
        chk("midreset_reack", 8'(host_ack), 8'd1);
        host_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("midreset_restart", 8'(ramping), 8'd1);
        n = 0;
        while (duty_cur != 4'd1 && n < 4 * PER) begin cycle(); n++; end
        chk("midreset_first_step", 8'(duty_cur), 8'd1);

        // Random switch changes and host writes
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 299) == 0) sw = 4'($urandom_range(0, 15));
            if (host_req && host_ack) host_req = 1'b0;
            else if (!host_req && $urandom_range(0, 799) == 0) begin
                host_req  = 1'b1;
                host_duty = 4'($urandom_range(0, 15));
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
